// File: rtl/picosoc_bus_fabric.sv
// PicoRV32 native-bus interconnect: registered decode, latched slave request, registered response.
// Optional sticky bus-error interrupt when BUS_FABRIC_ERR_IRQ_EN is defined.
module picosoc_bus_fabric #(
    parameter int                        NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE     = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK     = {NUM_SLAVES{32'h0}},
    parameter int                        TIMEOUT_CYCLES = 255,
    parameter logic [31:0]               DEFAULT_RDATA  = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       mem_valid,
    input  logic                       mem_instr,
    input  logic [31:0]                mem_addr,
    input  logic [31:0]                mem_wdata,
    input  logic [3:0]                 mem_wstrb,
    output logic                       mem_ready,
    output logic [31:0]                mem_rdata,
    output logic [NUM_SLAVES-1:0]      s_valid,
    output logic                       s_instr,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    output logic [3:0]                 s_wstrb,
    input  logic [NUM_SLAVES-1:0]      s_ready,
    input  logic [32*NUM_SLAVES-1:0]   s_rdata,
`ifdef BUS_FABRIC_ERR_IRQ_EN
    output logic                       irq_buserr,
    input  logic                       irq_ack,
`endif
    output logic                       bus_err,
    output logic [31:0]                err_addr
);

    localparam int          IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'h0;

    typedef enum logic [1:0] {IDLE, ACTIVE, ERROR, RESP} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, hit_idx;
    logic             any_hit;
    logic [31:0]      cnt;
    logic             sel_ready;
    logic [31:0]      sel_rdata;
    logic             timeout_hit;

    // Lowest-numbered matching window wins when windows overlap.
    always_comb begin
        any_hit = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (((mem_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) && !any_hit) begin
                any_hit = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        s_valid   = '0;
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (idx == IDX_W'(i)) begin
                s_valid[i] = (state == ACTIVE);
                sel_ready  = s_ready[i];
                sel_rdata  = s_rdata[32*i +: 32];
            end
        end
    end

    assign timeout_hit = TO_EN && (cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_valid) state_nxt = any_hit ? ACTIVE : ERROR;
            ACTIVE: begin
                if (sel_ready)        state_nxt = RESP;
                else if (timeout_hit) state_nxt = ERROR;
            end
            ERROR:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            bus_err   <= 1'b0;
            err_addr  <= '0;
            s_instr   <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_wstrb   <= '0;
        end else begin
            state     <= state_nxt;
            mem_ready <= (state_nxt == RESP);
            bus_err   <= (state == ERROR);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (mem_valid) begin
                        if (any_hit) begin
                            idx     <= hit_idx;
                            s_instr <= mem_instr;
                            s_addr  <= mem_addr;
                            s_wdata <= mem_wdata;
                            s_wstrb <= mem_wstrb;
                        end else begin
                            err_addr <= mem_addr;
                        end
                    end
                end
                ACTIVE: begin
                    cnt <= cnt + 32'd1;
                    if (sel_ready)        mem_rdata <= sel_rdata;
                    else if (timeout_hit) err_addr  <= s_addr;
                end
                ERROR:   mem_rdata <= DEFAULT_RDATA;
                default: cnt <= '0;
            endcase
        end
    end

`ifdef BUS_FABRIC_ERR_IRQ_EN
    always_ff @(posedge clk) begin
        if (!resetn)      irq_buserr <= 1'b0;
        else if (bus_err) irq_buserr <= 1'b1;
        else if (irq_ack) irq_buserr <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_picosoc_bus_fabric.sv
// Directed self-checking bench for picosoc_bus_fabric; irq checks enabled with BUS_FABRIC_ERR_IRQ_EN.
module tb_picosoc_bus_fabric;

    logic         clk = 1'b0;
    logic         resetn;
    logic         mem_valid, mem_instr;
    logic [31:0]  mem_addr, mem_wdata;
    logic [3:0]   mem_wstrb;
    logic         mem_ready;
    logic [31:0]  mem_rdata;
    logic [3:0]   s_valid;
    logic         s_instr;
    logic [31:0]  s_addr, s_wdata;
    logic [3:0]   s_wstrb;
    logic [3:0]   s_ready;
    logic [127:0] s_rdata;
    logic         bus_err;
    logic [31:0]  err_addr;
`ifdef BUS_FABRIC_ERR_IRQ_EN
    logic         irq_buserr, irq_ack;
`endif

    int checks = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    // slave3 overlaps slave0 at 0x100 so priority can be exercised
    picosoc_bus_fabric #(
        .NUM_SLAVES     (4),
        .SLAVE_BASE     ({32'h0000_0100, 32'h0300_0000, 32'h0200_0000, 32'h0000_0000}),
        .SLAVE_MASK     ({32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_F000}),
        .TIMEOUT_CYCLES (16),
        .DEFAULT_RDATA  (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .s_valid   (s_valid),
        .s_instr   (s_instr),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
`ifdef BUS_FABRIC_ERR_IRQ_EN
        .irq_buserr(irq_buserr),
        .irq_ack   (irq_ack),
`endif
        .bus_err   (bus_err),
        .err_addr  (err_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        s_ready   = '0;
        s_rdata   = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_0001, 32'h0000_AAAA};
`ifdef BUS_FABRIC_ERR_IRQ_EN
        irq_ack   = 1'b0;
`endif
        tick();
        tick();
        chk("rst_mem_ready", 32'(mem_ready), 32'h0);
        chk("rst_s_valid",   32'(s_valid),   32'h0);
        chk("rst_bus_err",   32'(bus_err),   32'h0);
        chk("rst_err_addr",  err_addr,       32'h0);
        chk("rst_mem_rdata", mem_rdata,      32'h0);
        chk("rst_s_addr",    s_addr,         32'h0);
`ifdef BUS_FABRIC_ERR_IRQ_EN
        chk("rst_irq",       32'(irq_buserr), 32'h0);
`endif
        resetn = 1'b1;
        tick();

        // zero-wait read from slave1
        mem_valid = 1'b1;
        mem_instr = 1'b1;
        mem_addr  = 32'h0200_0008;
        s_ready   = 4'b0010;
        tick();
        chk("zw_s_valid",   32'(s_valid),   32'h2);
        chk("zw_s_instr",   32'(s_instr),   32'h1);
        chk("zw_s_addr",    s_addr,         32'h0200_0008);
        chk("zw_ready_lo",  32'(mem_ready), 32'h0);
        tick();
        chk("zw_ready_hi",  32'(mem_ready), 32'h1);
        chk("zw_rdata",     mem_rdata,      32'hCAFE_0001);
        chk("zw_bus_err",   32'(bus_err),   32'h0);
        chk("zw_s_valid_off", 32'(s_valid), 32'h0);
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        s_ready   = '0;
        tick();
        chk("zw_ready_pulse", 32'(mem_ready), 32'h0);

        // write to slave2 with 5 wait states; CPU-side bus changes must not reach the slave
        mem_valid = 1'b1;
        mem_addr  = 32'h0300_0010;
        mem_wdata = 32'h1234_5678;
        mem_wstrb = 4'b0011;
        tick();
        mem_wdata = 32'hFFFF_FFFF;
        mem_wstrb = 4'b1111;
        for (int c = 1; c <= 6; c++) begin
            chk("ws_s_valid", 32'(s_valid),   32'h4);
            chk("ws_s_wdata", s_wdata,        32'h1234_5678);
            chk("ws_s_wstrb", 32'(s_wstrb),   32'h3);
            chk("ws_ready_lo", 32'(mem_ready), 32'h0);
            if (c == 6) s_ready = 4'b0100;
            tick();
        end
        chk("ws_ready_hi", 32'(mem_ready), 32'h1);
        chk("ws_rdata",    mem_rdata,      32'h2222_2222);
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        s_ready   = '0;
        tick();
        chk("ws_ready_pulse", 32'(mem_ready), 32'h0);

        // overlapping windows: slave0 must win over slave3
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0100;
        s_ready   = 4'b1001;
        tick();
        chk("ov_s_valid", 32'(s_valid), 32'h1);
        tick();
        chk("ov_ready_hi", 32'(mem_ready), 32'h1);
        chk("ov_rdata",    mem_rdata,      32'h0000_AAAA);
        mem_valid = 1'b0;
        s_ready   = '0;
        tick();

        // unmapped address
        mem_valid = 1'b1;
        mem_addr  = 32'h8000_0000;
        s_ready   = 4'b1111;
        tick();
        chk("um_s_valid",  32'(s_valid),   32'h0);
        chk("um_ready_lo", 32'(mem_ready), 32'h0);
        chk("um_err_lo",   32'(bus_err),   32'h0);
        tick();
        chk("um_ready_hi", 32'(mem_ready), 32'h1);
        chk("um_err_hi",   32'(bus_err),   32'h1);
        chk("um_rdata",    mem_rdata,      32'hDEAD_BEEF);
        chk("um_err_addr", err_addr,       32'h8000_0000);
        mem_valid = 1'b0;
        s_ready   = '0;
        tick();
        chk("um_err_pulse",  32'(bus_err),   32'h0);
        chk("um_ready_pulse", 32'(mem_ready), 32'h0);
        chk("um_err_hold",   err_addr,       32'h8000_0000);
`ifdef BUS_FABRIC_ERR_IRQ_EN
        chk("um_irq_set", 32'(irq_buserr), 32'h1);
        irq_ack = 1'b1;
        tick();
        chk("um_irq_ack", 32'(irq_buserr), 32'h0);
        irq_ack = 1'b0;
`endif

        // slave1 never responds: timeout after 16 ACTIVE cycles
        mem_valid = 1'b1;
        mem_addr  = 32'h0200_0004;
        s_ready   = '0;
        tick();
        n = 0;
        while (s_valid != 4'b0000 && n < 40) begin
            n++;
            tick();
        end
        chk("to_active_cycles", 32'(n),         32'd16);
        chk("to_ready_lo",      32'(mem_ready), 32'h0);
        chk("to_err_lo",        32'(bus_err),   32'h0);
        s_ready = 4'b0010;
        tick();
        chk("to_ready_hi",  32'(mem_ready), 32'h1);
        chk("to_err_hi",    32'(bus_err),   32'h1);
        chk("to_rdata",     mem_rdata,      32'hDEAD_BEEF);
        chk("to_err_addr",  err_addr,       32'h0200_0004);
`ifdef BUS_FABRIC_ERR_IRQ_EN
        irq_ack = 1'b1;
`endif
        mem_valid = 1'b0;
        tick();
        chk("to_ready_pulse", 32'(mem_ready), 32'h0);
        chk("to_late_ready",  32'(s_valid),   32'h0);
        chk("to_rdata_hold",  mem_rdata,      32'hDEAD_BEEF);
`ifdef BUS_FABRIC_ERR_IRQ_EN
        chk("to_irq_set_wins", 32'(irq_buserr), 32'h1);
        irq_ack = 1'b0;
        tick();
        chk("to_irq_sticky", 32'(irq_buserr), 32'h1);
        irq_ack = 1'b1;
        tick();
        chk("to_irq_ack", 32'(irq_buserr), 32'h0);
        irq_ack = 1'b0;
`endif
        s_ready = '0;
        tick();

        // reset in the middle of a long wait; a completing slave in that cycle is ignored
        mem_valid = 1'b1;
        mem_instr = 1'b1;
        mem_addr  = 32'h0300_0020;
        mem_wdata = 32'hA5A5_5A5A;
        mem_wstrb = 4'b1111;
        tick();
        chk("rm_s_valid", 32'(s_valid), 32'h4);
        tick();
        tick();
        resetn    = 1'b0;
        s_ready   = 4'b0100;
        mem_valid = 1'b0;
        tick();
        chk("rm_s_valid_off", 32'(s_valid),   32'h0);
        chk("rm_ready",       32'(mem_ready), 32'h0);
        chk("rm_s_addr",      s_addr,         32'h0);
        chk("rm_s_wdata",     s_wdata,        32'h0);
        chk("rm_s_wstrb",     32'(s_wstrb),   32'h0);
        chk("rm_s_instr",     32'(s_instr),   32'h0);
        chk("rm_err_addr",    err_addr,       32'h0);
        chk("rm_mem_rdata",   mem_rdata,      32'h0);
        chk("rm_bus_err",     32'(bus_err),   32'h0);
        resetn    = 1'b1;
        s_ready   = '0;
        mem_instr = 1'b0;
        mem_wstrb = 4'b0000;
        tick();
        chk("rm_no_resp_a", 32'(mem_ready), 32'h0);
        tick();
        chk("rm_no_resp_b", 32'(mem_ready), 32'h0);

        mem_valid = 1'b1;
        mem_addr  = 32'h0200_0008;
        s_ready   = 4'b0010;
        tick();
        chk("ra_s_valid", 32'(s_valid), 32'h2);
        tick();
        chk("ra_ready_hi", 32'(mem_ready), 32'h1);
        chk("ra_rdata",    mem_rdata,      32'hCAFE_0001);
        mem_valid = 1'b0;
        s_ready   = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/picosoc_bus_fabric.md
Name: picosoc_bus_fabric

Overview:
Parametrised native-bus interconnect between the PicoRV32 memory port and NUM_SLAVES memory-mapped targets such as ROM, RAM, UART and iomem. It replaces the hand-written address compares and ready/rdata mux in the SoC top. It registers the decode, shields slaves with latched address/data/strobe, and returns a registered response. Accesses to unmapped addresses and accesses to slaves that hang are terminated with an error response, so the CPU never stalls forever.

Parameters:
NUM_SLAVES, 4, number of slave ports (1..16)
SLAVE_BASE, {4{32'h0}}, packed 32*NUM_SLAVES base addresses; slave i occupies bits [32*i+31:32*i]
SLAVE_MASK, {4{32'h0}}, packed 32*NUM_SLAVES masks; slave i matches when (mem_addr & MASK_i) == BASE_i
TIMEOUT_CYCLES, 255, maximum ACTIVE cycles before forced termination; 0 disables the timeout
DEFAULT_RDATA, 32'h0000_0000, rdata returned on an error response

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
mem_valid  in  1  CPU request
mem_instr  in  1  CPU instruction fetch flag (passed through to slaves, registered)
mem_addr  in  32  CPU address
mem_wdata  in  32  CPU write data
mem_wstrb  in  4  CPU byte strobes; 0 means read
mem_ready  out  1  one-cycle completion pulse
mem_rdata  out  32  registered read data, valid while mem_ready=1
s_valid  out  NUM_SLAVES  one-hot slave request
s_instr  out  1  latched mem_instr
s_addr  out  32  latched address, shared by all slaves
s_wdata  out  32  latched write data, shared
s_wstrb  out  4  latched strobes, shared
s_ready  in  NUM_SLAVES  per-slave completion
s_rdata  in  32*NUM_SLAVES  packed per-slave read data
bus_err  out  1  one-cycle pulse on an unmapped or timed-out access
err_addr  out  32  address of the most recent error; holds until the next error

Behaviour:
- Clock and reset: one clock domain. resetn is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: state=IDLE, s_valid=0, mem_ready=0, mem_rdata=0, bus_err=0, err_addr=0, s_addr/s_wdata/s_wstrb/s_instr=0, timeout counter=0.
- Reset takes effect at the next edge even mid-transaction. s_valid drops with no response to the CPU. A slave that completes in that cycle is ignored.
- State machine:
  - IDLE -> ACTIVE: mem_valid=1 and at least one window matches. Latch addr, wdata, wstrb and instr. Latch index = lowest-numbered matching slave.
  - IDLE -> ERROR: mem_valid=1 and no window matches. Latch err_addr.
  - ACTIVE: s_valid[idx]=1, counter increments each cycle.
    - s_ready[idx]=1: capture s_rdata slice idx into mem_rdata, go to RESP.
    - Else, TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: go to ERROR, latch err_addr, drop s_valid.
    - If s_ready and timeout coincide, s_ready wins.
  - ERROR: mem_rdata<=DEFAULT_RDATA, go to RESP. bus_err pulses for exactly one cycle, coincident with RESP.
  - RESP: mem_ready=1 for one cycle; unconditional next state is IDLE. The counter clears on entry to IDLE.
- Latency: mem_ready is asserted 2 cycles after mem_valid is first sampled with a zero-wait slave (edge0 decode, edge1 s_ready seen, mem_ready high in cycle 2). Each slave wait cycle adds 1. Unmapped accesses also take 2 cycles.
- s_ready for non-selected slaves, and s_ready outside ACTIVE, is ignored.
- In IDLE, a new request is accepted on the same edge mem_valid is seen. Back-to-back CPU requests are therefore separated by at least one IDLE cycle.
- mem_valid dropping mid-transaction is a protocol violation. The transaction completes regardless.
- Writes: rdata is still captured; the CPU ignores it.

Optional Feature:
BUS_FABRIC_ERR_IRQ_EN
- Defined: adds ports irq_buserr (out, 1) and irq_ack (in, 1).
  - irq_buserr sets on any bus_err pulse and stays high until irq_ack=1 is sampled.
  - If bus_err and irq_ack occur in the same cycle, set wins.
  - irq_buserr resets to 0. It is intended for cpu irq[3].
- Undefined: neither port exists and there is no sticky state. bus_err and err_addr still operate.

Test Plan:
- Zero-wait read: slave1 BASE=32'h0200_0000, MASK=32'hFFFF_FF00, mem_addr=32'h0200_0008, s_ready[1] tied 1, s_rdata1=32'hCAFE_0001 -> s_valid=4'b0010 for 1 cycle; mem_ready pulses 2 cycles after mem_valid; mem_rdata=32'hCAFE_0001; bus_err=0.
- Wait-state write: slave2, wstrb=4'b0011, wdata=32'h1234_5678, s_ready[2] after 5 cycles -> s_wdata/s_wstrb stable through the 6 ACTIVE cycles; mem_ready 7 cycles after mem_valid.
- Overlap priority: slaves 0 and 3 both match 32'h0000_0100 -> only s_valid[0] asserts; s_rdata3 is never returned.
- Unmapped: DEFAULT_RDATA=32'hDEAD_BEEF, mem_addr=32'h8000_0000 -> no s_valid; mem_ready and bus_err pulse together 2 cycles later; mem_rdata=32'hDEAD_BEEF; err_addr=32'h8000_0000.
- Timeout: TIMEOUT_CYCLES=16, slave never ready -> s_valid high exactly 16 cycles, then bus_err and mem_ready pulse; a late s_ready afterwards is ignored. With the macro defined, irq_buserr stays 1 until irq_ack.
- Reset mid-ACTIVE: resetn=0 for 1 cycle during a 10-cycle wait -> all outputs at reset values next cycle; no mem_ready; a following access completes normally.
